// File: rtl/regfile_scoreboard.sv
// Register file with combinational read ports, write-back bypass and a per-register
// busy scoreboard that tracks long-latency ops from issue to retirement.
module regfile_scoreboard #(
  parameter  int unsigned DATA_W   = 32,
  parameter  int unsigned NUM_REGS = 32,
  parameter  int unsigned NUM_RD   = 2,
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS),
  localparam int unsigned CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_sel,
  input  logic [NUM_RD-1:0]          rd_use,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic                       stall,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_sel,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_clr,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_sel,
  output logic [NUM_REGS-1:0]        busy_vec,
  output logic [CNT_W-1:0]           pend_cnt,
  output logic                       err,
  input  logic                       err_clr
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic                wr_ok;
  logic                clr_en;
  logic                iss_ok;
  logic                dup_iss;
  logic                bad_clr;
  logic [ADDR_W-1:0]   rd_addr;

  // Register 0 is hardwired to zero: it is never written, never busy.
  assign wr_ok   = wr_en && (wr_sel != '0);
  assign clr_en  = wr_en && wr_clr;
  assign iss_ok  = iss_en && (iss_sel != '0);

  // Protocol errors: re-issue to a register still pending, or retiring one never issued.
  assign dup_iss = iss_ok && busy_q[iss_sel] && !(clr_en && (wr_sel == iss_sel));
  assign bad_clr = clr_en && !busy_q[wr_sel];

  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[wr_sel] = wr_data;
    end
  end

  // Clear first so a same-cycle issue to the retiring register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[wr_sel] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[iss_sel] = 1'b1;
    end
  end

  always_comb begin
    cnt_d = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      cnt_d = cnt_d + CNT_W'(busy_d[r]);
    end
  end

  // A new error wins over a concurrent clear request.
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 1'b0;
    end
    if (dup_iss || bad_clr) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // Read ports with write-back bypass; a retiring write hides the busy bit it clears.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    rd_addr = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_addr = rd_sel[i*ADDR_W +: ADDR_W];
      if (rd_addr != '0) begin
        if (wr_en && (wr_sel == rd_addr)) begin
          rd_data[i*DATA_W +: DATA_W] = wr_data;
        end else begin
          rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr];
        end
        rd_busy[i] = busy_q[rd_addr] && !(clr_en && (wr_sel == rd_addr));
      end
    end
  end

  assign stall    = |(rd_busy & rd_use);
  assign busy_vec = busy_q;
  assign pend_cnt = cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: stimulus pushes expected outputs into a queue,
// a negedge monitor pops and compares them against the DUT.
module tb_regfile_scoreboard;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned NUM_RD   = 2;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned CNT_W    = 6;

  localparam int unsigned M_RD0 = 1, M_RD1 = 2, M_RBSY = 4, M_STL = 8,
                          M_BVEC = 16, M_CNT = 32, M_ERR = 64;

  typedef struct {
    string       name;
    int unsigned mask;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [1:0]  rbsy;
    logic        stl;
    logic [31:0] bvec;
    logic [5:0]  cnt;
    logic        er;
  } exp_t;

  logic                     clk;
  logic                     rst;
  logic [NUM_RD*ADDR_W-1:0] rd_sel;
  logic [NUM_RD-1:0]        rd_use;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     stall;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_sel;
  logic [DATA_W-1:0]        wr_data;
  logic                     wr_clr;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_sel;
  logic [NUM_REGS-1:0]      busy_vec;
  logic [CNT_W-1:0]         pend_cnt;
  logic                     err;
  logic                     err_clr;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  regfile_scoreboard #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) dut (
    .clk(clk), .rst(rst), .rd_sel(rd_sel), .rd_use(rd_use), .rd_data(rd_data),
    .rd_busy(rd_busy), .stall(stall), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .wr_clr(wr_clr), .iss_en(iss_en), .iss_sel(iss_sel),
    .busy_vec(busy_vec), .pend_cnt(pend_cnt), .err(err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h want 0x%0h", nm, fld, act, want);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if ((e.mask & M_RD0)  != 0) cmp(e.name, "rd0",  rd_data[31:0], e.rd0);
      if ((e.mask & M_RD1)  != 0) cmp(e.name, "rd1",  rd_data[63:32], e.rd1);
      if ((e.mask & M_RBSY) != 0) cmp(e.name, "rd_busy", 32'(rd_busy), 32'(e.rbsy));
      if ((e.mask & M_STL)  != 0) cmp(e.name, "stall", 32'(stall), 32'(e.stl));
      if ((e.mask & M_BVEC) != 0) cmp(e.name, "busy_vec", busy_vec, e.bvec);
      if ((e.mask & M_CNT)  != 0) cmp(e.name, "pend_cnt", 32'(pend_cnt), 32'(e.cnt));
      if ((e.mask & M_ERR)  != 0) cmp(e.name, "err", 32'(err), 32'(e.er));
    end
  end

  task automatic push_exp(input string nm, input int unsigned m,
                          input logic [31:0] r0, input logic [31:0] r1,
                          input logic [1:0] rb, input logic st,
                          input logic [31:0] bv, input logic [5:0] cn, input logic er);
    exp_t e;
    e.name = nm; e.mask = m; e.rd0 = r0; e.rd1 = r1; e.rbsy = rb;
    e.stl = st; e.bvec = bv; e.cnt = cn; e.er = er;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_clr = 1'b0; iss_en = 1'b0; err_clr = 1'b0; rst = 1'b0;
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                        input logic [1:0] use_v);
    rd_sel = {a1, a0};
    rd_use = use_v;
  endtask

  localparam int unsigned ALL = M_RD0 | M_RD1 | M_RBSY | M_STL | M_BVEC | M_CNT | M_ERR;

  initial begin
    rst = 1'b1; rd_sel = '0; rd_use = '0; wr_en = 1'b0; wr_sel = '0; wr_data = '0;
    wr_clr = 1'b0; iss_en = 1'b0; iss_sel = '0; err_clr = 1'b0;
    step(); step();
    idle();
    push_exp("reset", ALL, 0, 0, 2'b00, 0, 0, 0, 0);

    // Bypass then stored value
    step();
    wr_en = 1; wr_sel = 5; wr_data = 32'hDEADBEEF; set_rd(5, 0, 2'b00);
    push_exp("bypass_r5", M_RD0 | M_RD1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    step(); idle();
    push_exp("stored_r5", M_RD0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);

    // Register 0 ignores writes and issues
    step();
    wr_en = 1; wr_sel = 0; wr_data = 32'h1234; set_rd(0, 5, 2'b00);
    push_exp("r0_wr_nobypass", M_RD0 | M_RD1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(); idle();
    iss_en = 1; iss_sel = 0;
    push_exp("r0_read", M_RD0, 0, 0, 0, 0, 0, 0, 0);
    step(); idle();
    push_exp("r0_iss", M_BVEC | M_CNT | M_ERR, 0, 0, 0, 0, 0, 0, 0);

    // Issue r7, stall on use, retire with bypass
    step();
    iss_en = 1; iss_sel = 7;
    step(); idle();
    set_rd(5, 7, 2'b10);
    push_exp("r7_stall", M_RBSY | M_STL | M_CNT | M_BVEC, 0, 0, 2'b10, 1, 32'h80, 1, 0);
    step();
    set_rd(7, 5, 2'b10);
    push_exp("r7_unused", M_RBSY | M_STL, 0, 0, 2'b01, 0, 0, 0, 0);
    step();
    set_rd(5, 7, 2'b10);
    wr_en = 1; wr_clr = 1; wr_sel = 7; wr_data = 32'h55;
    push_exp("r7_retire", M_RD1 | M_RBSY | M_STL | M_CNT, 0, 32'h55, 2'b00, 0, 0, 1, 0);
    step(); idle();
    push_exp("r7_after", M_RD1 | M_CNT | M_BVEC | M_ERR | M_STL, 0, 32'h55, 0, 0, 0, 0, 0);

    // r9: same-cycle issue and retire keeps busy; duplicate issue flags err
    step();
    iss_en = 1; iss_sel = 9;
    step(); idle();
    iss_en = 1; iss_sel = 9; wr_en = 1; wr_clr = 1; wr_sel = 9; wr_data = 32'h99;
    step(); idle();
    push_exp("r9_setwins", M_BVEC | M_CNT | M_ERR, 0, 0, 0, 0, 32'h200, 1, 0);
    step();
    iss_en = 1; iss_sel = 9;
    step(); idle();
    push_exp("r9_dup", M_BVEC | M_ERR, 0, 0, 0, 0, 32'h200, 0, 1);
    step();
    push_exp("r9_hold", M_ERR, 0, 0, 0, 0, 0, 0, 1);
    err_clr = 1;
    step(); idle();
    push_exp("r9_errclr", M_ERR, 0, 0, 0, 0, 0, 0, 0);
    wr_en = 1; wr_clr = 1; wr_sel = 9; wr_data = 0;
    step(); idle();
    push_exp("r9_retire", M_BVEC | M_CNT | M_ERR, 0, 0, 0, 0, 0, 0, 0);

    // Spurious retire of r3; err_clr loses to a concurrent error
    step();
    wr_en = 1; wr_clr = 1; wr_sel = 3; wr_data = 32'h333;
    step(); idle();
    set_rd(3, 0, 2'b00);
    push_exp("r3_spurious", M_RD0 | M_BVEC | M_ERR, 32'h333, 0, 0, 0, 0, 0, 1);
    step();
    err_clr = 1; wr_en = 1; wr_clr = 1; wr_sel = 4; wr_data = 32'h444;
    step(); idle();
    push_exp("errclr_vs_new", M_ERR | M_BVEC, 0, 0, 0, 0, 0, 0, 1);
    step();
    err_clr = 1;
    step(); idle();
    push_exp("errclr_final", M_ERR, 0, 0, 0, 0, 0, 0, 0);

    // Fill the scoreboard, then reset overrides concurrent activity
    step();
    for (int r = 1; r < 32; r++) begin
      iss_en = 1; iss_sel = ADDR_W'(r);
      step();
    end
    idle();
    set_rd(5, 7, 2'b01);
    push_exp("full", M_BVEC | M_CNT | M_ERR | M_RBSY | M_STL,
             0, 0, 2'b11, 1, 32'hFFFF_FFFE, 6'd31, 0);
    step();
    rst = 1; iss_en = 1; iss_sel = 1; wr_en = 1; wr_sel = 5; wr_data = 32'hFFFF;
    wr_clr = 0;
    step(); idle();
    set_rd(5, 7, 2'b11);
    push_exp("post_rst", ALL, 0, 0, 2'b00, 0, 0, 0, 0);
    for (int r = 1; r < 32; r++) begin
      step();
      set_rd(ADDR_W'(r), 3, 2'b11);
      push_exp($sformatf("rst_r%0d", r), M_RD0 | M_RD1 | M_STL, 0, 0, 0, 0, 0, 0, 0);
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) step();
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
